// File: rtl/add_speed_pkg.sv
// Shared helpers for the *_speed adder timing probes: default operand widths,
// width calculators and fixed-width operand/result typedefs.
package add_speed_pkg;

   // Result width that can never overflow for a signed add or subtract.
   function automatic int unsigned calc_c_bits(input int unsigned a_bits,
                                               input int unsigned b_bits);
      return ((a_bits > b_bits) ? a_bits : b_bits) + 1;
   endfunction

   // Segment width is ceil(c_bits/stages). A zero stage count is guarded here
   // so the top can still reach its own range check.
   function automatic int unsigned calc_seg_bits(input int unsigned c_bits,
                                                 input int unsigned stages);
      return (stages == 0) ? c_bits : (c_bits + stages - 1) / stages;
   endfunction

   localparam int unsigned DEF_A_BITS = 64;
   localparam int unsigned DEF_B_BITS = 64;
   localparam int unsigned DEF_C_BITS = calc_c_bits(DEF_A_BITS, DEF_B_BITS);

   typedef logic signed [DEF_A_BITS-1:0] a_t;
   typedef logic signed [DEF_B_BITS-1:0] b_t;
   typedef logic signed [DEF_C_BITS-1:0] c_t;

endpackage

// File: rtl/add_pipe_seg.sv
// One registered carry-chain segment.
// Adds bits [LO_BITS +: SEG_BITS] of a_i and b_i plus carry_i. Bits of a_i
// below LO_BITS are finished sums and are forwarded unchanged; bits above the
// segment are forwarded unchanged so later stages can consume them. In a_o the
// segment field is replaced by its sum; in b_o the consumed bits are cleared.
// Ports:
//   clk, reset (sync, active-high), cke (clock enable)
//   valid_i/valid_o   op valid in / registered out
//   carry_i/carry_o   carry into this segment / registered carry-out
//   a_i/a_o, b_i/b_o  full-width operand/sum vectors in / registered out
module add_pipe_seg #(
   parameter int unsigned SEG_BITS  = 17,
   parameter int unsigned PASS_BITS = 0,
   parameter int unsigned LO_BITS   = 0
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  cke,
   input  logic                                  valid_i,
   input  logic                                  carry_i,
   input  logic [LO_BITS+SEG_BITS+PASS_BITS-1:0] a_i,
   input  logic [LO_BITS+SEG_BITS+PASS_BITS-1:0] b_i,
   output logic                                  valid_o,
   output logic                                  carry_o,
   output logic [LO_BITS+SEG_BITS+PASS_BITS-1:0] a_o,
   output logic [LO_BITS+SEG_BITS+PASS_BITS-1:0] b_o
);

   localparam int unsigned W     = LO_BITS + SEG_BITS + PASS_BITS;
   localparam int unsigned SUM_W = SEG_BITS + 1;

   logic [SUM_W-1:0] seg_sum;
   logic [W-1:0]     a_d;
   logic [W-1:0]     b_d;

   (* dont_touch = "true" *) logic         valid_q;
   (* dont_touch = "true" *) logic         carry_q;
   (* dont_touch = "true" *) logic [W-1:0] a_q;
   (* dont_touch = "true" *) logic [W-1:0] b_q;

   // Segment add; the extra MSB of seg_sum is the carry-out.
   always_comb begin
      seg_sum = {1'b0, a_i[LO_BITS +: SEG_BITS]}
              + {1'b0, b_i[LO_BITS +: SEG_BITS]}
              + SUM_W'(carry_i);
      a_d = a_i;
      a_d[LO_BITS +: SEG_BITS] = seg_sum[SEG_BITS-1:0];
      b_d = b_i;
      b_d[LO_BITS+SEG_BITS-1:0] = '0;
   end

   // Segment pipeline register, frozen while cke is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
      end else if (cke) begin
         valid_q <= valid_i;
         carry_q <= seg_sum[SEG_BITS];
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   assign valid_o = valid_q;
   assign carry_o = carry_q;
   assign a_o     = a_q;
   assign b_o     = b_q;

endmodule

// File: rtl/add_pipe_speed.sv
// Pipelined signed add/subtract timing probe.
// Operands are shifted in serially, captured on load, then summed through a
// carry chain split into STAGES registered segments. The full-precision result
// is held in c0_q and reduced to a single pin by XOR.
// Ports:
//   clk, reset (sync, active-high), cke (pipeline clock enable)
//   a, b     serial operand bits, shifted in every clock
//   sub      0: a+b, 1: a-b (sampled with load, ignored when SUB_EN=0)
//   load     capture the shift registers and start an op
//   c        XOR reduction of c0_q
//   c_valid  c0_q/c hold the result of a completed op
(* use_dsp = "no" *)
module add_pipe_speed
   import add_speed_pkg::*;
#(
   parameter int unsigned A_BITS = DEF_A_BITS,
   parameter int unsigned B_BITS = DEF_B_BITS,
   parameter int unsigned C_BITS = calc_c_bits(A_BITS, B_BITS),
   parameter int unsigned STAGES = 4,
   parameter int unsigned SUB_EN = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic cke,
   input  logic a,
   input  logic b,
   input  logic sub,
   input  logic load,
   output logic c,
   output logic c_valid
);

   localparam int unsigned SEG_BITS = calc_seg_bits(C_BITS, STAGES);
   // The chain runs on a width padded up to whole segments; sign extension
   // keeps the low C_BITS exact, and the padding is dropped at c0_q.
   localparam int unsigned W_PAD    = SEG_BITS * STAGES;

   if (STAGES < 1 || STAGES > C_BITS) begin : g_bad_stages
      $error("add_pipe_speed: STAGES=%0d must be in 1..C_BITS=%0d", STAGES, C_BITS);
   end

   logic [A_BITS-1:0] as_q;
   logic [B_BITS-1:0] bs_q;

   (* dont_touch = "true" *) logic signed [A_BITS-1:0] a0_q;
   (* dont_touch = "true" *) logic signed [B_BITS-1:0] b0_q;
   (* dont_touch = "true" *) logic                     sub0_q;
   (* dont_touch = "true" *) logic                     v0_q;
   (* dont_touch = "true" *) logic [C_BITS-1:0]        c0_q;
   (* dont_touch = "true" *) logic                     c_valid_q;

   logic [STAGES:0][W_PAD-1:0] a_chain;
   logic [STAGES:0][W_PAD-1:0] b_chain;
   logic [STAGES:0]            carry_chain;
   logic [STAGES:0]            valid_chain;
   logic                       unused_tail;

   // Serial operand shift registers: free-running, no reset, no enable.
   always_ff @(posedge clk) begin
      as_q <= {as_q[A_BITS-2:0], a};
      bs_q <= {bs_q[B_BITS-2:0], b};
   end

   // Operand capture. v0_q is a one-cycle start pulse per accepted load.
   always_ff @(posedge clk) begin
      if (reset) begin
         a0_q   <= '0;
         b0_q   <= '0;
         sub0_q <= 1'b0;
         v0_q   <= 1'b0;
      end else if (cke) begin
         v0_q <= load;
         if (load) begin
            a0_q   <= as_q;
            b0_q   <= bs_q;
            sub0_q <= sub & (SUB_EN != 0);
         end
      end
   end

   // Subtract as a + ~b + 1: invert B and feed the +1 as the chain carry-in.
   assign a_chain[0]     = W_PAD'(a0_q);
   assign b_chain[0]     = W_PAD'(b0_q) ^ {W_PAD{sub0_q}};
   assign carry_chain[0] = sub0_q;
   assign valid_chain[0] = v0_q;

   for (genvar k = 0; k < STAGES; k++) begin : g_seg
      add_pipe_seg #(
         .SEG_BITS  (SEG_BITS),
         .PASS_BITS (W_PAD - (k + 1) * SEG_BITS),
         .LO_BITS   (k * SEG_BITS)
      ) u_seg (
         .clk     (clk),
         .reset   (reset),
         .cke     (cke),
         .valid_i (valid_chain[k]),
         .carry_i (carry_chain[k]),
         .a_i     (a_chain[k]),
         .b_i     (b_chain[k]),
         .valid_o (valid_chain[k+1]),
         .carry_o (carry_chain[k+1]),
         .a_o     (a_chain[k+1]),
         .b_o     (b_chain[k+1])
      );
   end

   // Result register: loads only on a valid op, otherwise holds its last value.
   always_ff @(posedge clk) begin
      if (reset) begin
         c0_q      <= '0;
         c_valid_q <= 1'b0;
      end else if (cke) begin
         c_valid_q <= valid_chain[STAGES];
         if (valid_chain[STAGES]) begin
            c0_q <= a_chain[STAGES][C_BITS-1:0];
         end
      end
   end

   // Final carry, drained B vector and padding bits carry no information.
   assign unused_tail = ^{carry_chain[STAGES], b_chain[STAGES], a_chain[STAGES]};

   assign c       = ^c0_q;
   assign c_valid = c_valid_q;

endmodule

// File: tb/tb_add_pipe_speed.sv
// Scoreboard bench for add_pipe_speed: a default instance and a SUB_EN=0
// instance share all inputs; expected results are queued at load and popped
// by a monitor whenever a fresh result is presented.
module tb_add_pipe_speed;
   import add_speed_pkg::*;

   localparam int unsigned LAT = 5;

   logic clk = 1'b0;
   logic reset, cke, a, b, sub, load;
   logic c, c_valid, c_ns, c_valid_ns;

   always #5 clk = ~clk;

   add_pipe_speed dut (
      .clk(clk), .reset(reset), .cke(cke), .a(a), .b(b), .sub(sub), .load(load),
      .c(c), .c_valid(c_valid)
   );

   add_pipe_speed #(.SUB_EN(0)) dut_ns (
      .clk(clk), .reset(reset), .cke(cke), .a(a), .b(b), .sub(sub), .load(load),
      .c(c_ns), .c_valid(c_valid_ns)
   );

   typedef struct {
      int unsigned due;
      c_t          c0;
   } exp_t;

   exp_t        q_m[$];
   exp_t        q_n[$];
   exp_t        e_m, e_n;
   int          checks   = 0;
   int          failures = 0;
   int unsigned ecnt     = 0;
   logic        fresh    = 1'b0;

   // Count cke-qualified edges; latency is measured in these.
   always @(posedge clk) begin
      if (!reset && cke) ecnt <= ecnt + 1;
      fresh <= !reset && cke;
   end

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare every freshly presented result against the queue head.
   always @(negedge clk) begin
      if (fresh && c_valid) begin
         if (q_m.size() == 0) chk("main_unexpected_valid", 65'(c_valid), 65'd0);
         else begin
            e_m = q_m.pop_front();
            chk("main_c0", dut.c0_q, e_m.c0);
            chk("main_c", 65'(c), 65'(^e_m.c0));
            chk("main_latency", 65'(ecnt), 65'(e_m.due));
         end
      end
      if (fresh && c_valid_ns) begin
         if (q_n.size() == 0) chk("nosub_unexpected_valid", 65'(c_valid_ns), 65'd0);
         else begin
            e_n = q_n.pop_front();
            chk("nosub_c0", dut_ns.c0_q, e_n.c0);
            chk("nosub_c", 65'(c_ns), 65'(^e_n.c0));
            chk("nosub_latency", 65'(ecnt), 65'(e_n.due));
         end
      end
   end

   // One clock of stimulus; an accepted load queues its expected results.
   task automatic cyc(input logic ld, input logic sb, input logic ab, input logic bb,
                      input logic ck, input c_t em, input c_t en);
      load = ld; sub = sb; a = ab; b = bb; cke = ck;
      @(posedge clk);
      #1;
      if (ld && ck && !reset) begin
         q_m.push_back('{due: ecnt + LAT, c0: em});
         q_n.push_back('{due: ecnt + LAT, c0: en});
      end
      load = 1'b0;
   endtask

   task automatic shift_in(input logic [63:0] va, input logic [63:0] vb);
      for (int i = 63; i >= 0; i--) cyc(1'b0, 1'b0, va[i], vb[i], 1'b1, '0, '0);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (q_m.size() + q_n.size()) != 0; i++)
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
      chk("drain_pending", 65'(q_m.size() + q_n.size()), 65'd0);
   endtask

   task automatic op(input logic [63:0] va, input logic [63:0] vb, input logic sb,
                     input c_t em, input c_t en);
      shift_in(va, vb);
      cyc(1'b1, sb, 1'b0, 1'b0, 1'b1, em, en);
      drain();
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_c0"}, dut.c0_q, 65'd0);
      chk({tag, "_c"}, 65'(c), 65'd0);
      chk({tag, "_c_valid"}, 65'(c_valid), 65'd0);
      chk({tag, "_nosub_c_valid"}, 65'(c_valid_ns), 65'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; cke = 1'b0; a = 1'b0; b = 1'b0; sub = 1'b0; load = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_idle("reset");

      op(64'd1, 64'd1, 1'b0, 65'd2, 65'd2);
      op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 65'd0, 65'd0);
      op(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0,
         65'h0_FFFF_FFFF_FFFF_FFFE, 65'h0_FFFF_FFFF_FFFF_FFFE);
      op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
         65'h1_0000_0000_0000_0000, 65'h1_0000_0000_0000_0000);
      op(64'd0, 64'd1, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFF, 65'd1);
      op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
         65'h0_2222_2222_2222_2211, 65'h0_2222_2222_2222_2211);
      op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
         65'h0_0246_8ACF_1357_9BCF, 65'h0_2222_2222_2222_2211);

      // Back-to-back: A window slides 1 -> 2 -> 5 while B stays -1.
      shift_in(64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 65'd0, 65'd0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 65'd1, 65'd1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 65'd6, 65'd4);
      drain();

      // Stall mid-pipeline; the load issued with cke low must be ignored.
      shift_in(64'd5, 64'd3);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 65'd2, 65'd8);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      drain();
      repeat (8) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

      // Reset two cycles after a load: the op must vanish.
      shift_in(64'd1, 64'd1);
      load = 1'b1; cke = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_idle("midreset");
      reset = 1'b0;
      repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
      op(64'd1, 64'd1, 1'b0, 65'd2, 65'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
